// File: rtl/qmm_pkg.sv
// Shared state encoding, mode encodings and default geometry for the quantized matrix multiplier.
// No logic here; latency and backpressure are properties of qmm_multiplier.
package qmm_pkg;
  localparam int L_RAM_SIZE_DEF = 3;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int WORD_WIDTH_DEF = 32;
  localparam int ACC_WIDTH_DEF  = 32;

  localparam int N     = 1 << L_RAM_SIZE_DEF;
  localparam int LANES = WORD_WIDTH_DEF / DATA_WIDTH_DEF;
  localparam int W     = N * N / LANES;

  localparam logic MODE_RAW   = 1'b0;
  localparam logic MODE_QUANT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_STORE,
    ST_DONE
  } state_t;
endpackage

// File: rtl/qmm_if.sv
// Job control plus shared single-port BRAM bus of the matrix multiplier.
// master = multiplier side (drives BRAM address/data); slave = host and BRAM side.
interface qmm_if #(
  parameter int AW = 7,
  parameter int WW = 32
);
  logic          start;
  logic          mode;
  logic [4:0]    shift;
  logic [WW-1:0] rddata;
  logic [AW-1:0] addr;
  logic [WW-1:0] wrdata;
  logic          we;
  logic          busy;
  logic          done;

  modport master (input start, mode, shift, rddata, output addr, wrdata, we, busy, done);
  modport slave  (output start, mode, shift, rddata, input addr, wrdata, we, busy, done);
endinterface

// File: rtl/qmm_requant.sv
// Rounding arithmetic right shift of an accumulator followed by saturation to DATA_WIDTH.
// Purely combinational, zero latency, no backpressure.
module qmm_requant #(
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0]  i_acc,
  input  logic        [4:0]            i_shift,
  output logic signed [DATA_WIDTH-1:0] o_q
);
  localparam logic signed [ACC_WIDTH:0] QMAX = (ACC_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] QMIN = ~QMAX;

  logic signed [ACC_WIDTH:0] w_ext;
  logic signed [ACC_WIDTH:0] w_rnd;
  logic signed [ACC_WIDTH:0] w_r;

  // One guard bit keeps acc + half-LSB from wrapping.
  always_comb begin
    w_ext = {i_acc[ACC_WIDTH-1], i_acc};
    w_rnd = '0;
    if (i_shift != 5'd0) w_rnd = (ACC_WIDTH+1)'(1) << (i_shift - 5'd1);
    w_r = (w_ext + w_rnd) >>> i_shift;
    o_q = DATA_WIDTH'(w_r);
    if (w_r > QMAX) o_q = DATA_WIDTH'(QMAX);
    else if (w_r < QMIN) o_q = DATA_WIDTH'(QMIN);
  end
endmodule

// File: rtl/qmm_multiplier.sv
// Quantized NxN matrix multiply C = A*B: loads A/B from a shared BRAM, MACs one row of C per N cycles, writes it back.
// Job takes 2W+2+N*(N+S) cycles from start; no backpressure, the BRAM accepts one access every cycle.
module qmm_multiplier
  import qmm_pkg::*;
#(
  parameter int L_RAM_SIZE = L_RAM_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input logic   aclk,
  input logic   aresetn,
  qmm_if.master bus
);
  localparam int C_N     = 1 << L_RAM_SIZE;
  localparam int C_LANES = WORD_WIDTH / DATA_WIDTH;
  localparam int C_W     = C_N * C_N / C_LANES;
  localparam int C_WPR   = C_N / C_LANES;
  localparam int AW      = 2 * L_RAM_SIZE + 1;
  localparam int LW      = L_RAM_SIZE;
  localparam int EW      = 2 * L_RAM_SIZE;

  state_t r_state, w_state_nxt;
  logic [AW-1:0]         r_cnt, r_addr, w_wr_addr, w_widx;
  logic [LW-1:0]         r_row, w_k;
  logic                  r_mode, r_we;
  logic [4:0]            r_shift;
  logic [WORD_WIDTH-1:0] r_wrdata, w_wr_data;
  logic [EW-1:0]         w_cap_base;
  logic                  w_load_last, w_calc_last, w_store_last;

  logic signed [DATA_WIDTH-1:0] r_a [C_N*C_N];
  logic signed [DATA_WIDTH-1:0] r_b [C_N*C_N];
  logic signed [ACC_WIDTH-1:0]  r_acc [C_N];
  logic signed [ACC_WIDTH-1:0]  w_acc_nxt [C_N];
  logic signed [ACC_WIDTH-1:0]  w_src [C_N];
  logic signed [ACC_WIDTH-1:0]  w_lane_acc [C_LANES];
  logic signed [DATA_WIDTH-1:0] w_lane_q [C_LANES];

  assign w_k          = r_cnt[LW-1:0];
  assign w_load_last  = (r_state == ST_LOAD) && (r_cnt == AW'(2 * C_W));
  assign w_calc_last  = (r_state == ST_CALC) && (r_cnt == AW'(C_N - 1));
  assign w_store_last = (r_state == ST_STORE) &&
                        (r_cnt == ((r_mode == MODE_QUANT) ? AW'(C_WPR - 1) : AW'(C_N - 1)));
  // Word m lands at element m*LANES; the EW-bit wrap folds B's words onto its own buffer.
  assign w_cap_base   = EW'((int'(r_cnt) - 1) * C_LANES);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_load_last) w_state_nxt = ST_CALC;
      ST_CALC:  if (w_calc_last) w_state_nxt = ST_STORE;
      ST_STORE: if (w_store_last) w_state_nxt = (r_row == LW'(C_N - 1)) ? ST_DONE : ST_CALC;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // The first word of a row is written on the cycle after the last MAC, so it is taken from w_acc_nxt.
  always_comb begin
    for (int j = 0; j < C_N; j++) begin
      w_acc_nxt[j] = ACC_WIDTH'(r_a[{r_row, w_k}]) * ACC_WIDTH'(r_b[{w_k, LW'(j)}]);
      if (r_cnt != '0) w_acc_nxt[j] = w_acc_nxt[j] + r_acc[j];
      w_src[j] = (r_state == ST_CALC) ? w_acc_nxt[j] : r_acc[j];
    end
    w_widx = (r_state == ST_CALC) ? '0 : r_cnt + AW'(1);
    for (int l = 0; l < C_LANES; l++)
      w_lane_acc[l] = w_src[LW'(int'(w_widx) * C_LANES + l)];
  end

  for (genvar l = 0; l < C_LANES; l++) begin : g_rq
    qmm_requant #(.ACC_WIDTH(ACC_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rq (
      .i_acc   (w_lane_acc[l]),
      .i_shift (r_shift),
      .o_q     (w_lane_q[l])
    );
  end

  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    if (r_mode == MODE_QUANT) begin
      w_wr_addr = AW'(2 * C_W + int'(r_row) * C_WPR + int'(w_widx));
      for (int l = 0; l < C_LANES; l++)
        w_wr_data[l*DATA_WIDTH +: DATA_WIDTH] = w_lane_q[l];
    end else begin
      w_wr_addr = AW'(2 * C_W + int'(r_row) * C_N + int'(w_widx));
      w_wr_data = WORD_WIDTH'(w_src[w_widx[LW-1:0]]);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_row    <= '0;
      r_mode   <= MODE_RAW;
      r_shift  <= '0;
      r_we     <= 1'b0;
      r_wrdata <= '0;
      for (int e = 0; e < C_N * C_N; e++) begin
        r_a[e] <= '0;
        r_b[e] <= '0;
      end
      for (int j = 0; j < C_N; j++) r_acc[j] <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_mode  <= bus.mode;
          r_shift <= bus.shift;
          r_cnt   <= '0;
          r_addr  <= '0;
          r_row   <= '0;
        end
        ST_LOAD: begin
          r_cnt  <= w_load_last ? '0 : r_cnt + AW'(1);
          r_addr <= (r_cnt < AW'(2 * C_W - 1)) ? r_cnt + AW'(1) : '0;
          if (r_cnt != '0) begin
            for (int l = 0; l < C_LANES; l++) begin
              if (r_cnt <= AW'(C_W)) r_a[w_cap_base + EW'(l)] <= bus.rddata[l*DATA_WIDTH +: DATA_WIDTH];
              else                   r_b[w_cap_base + EW'(l)] <= bus.rddata[l*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        ST_CALC: begin
          for (int j = 0; j < C_N; j++) r_acc[j] <= w_acc_nxt[j];
          r_cnt <= w_calc_last ? '0 : r_cnt + AW'(1);
          if (w_calc_last) begin
            r_we     <= 1'b1;
            r_addr   <= w_wr_addr;
            r_wrdata <= w_wr_data;
          end
        end
        ST_STORE: begin
          if (w_store_last) begin
            r_cnt <= '0;
            r_row <= r_row + LW'(1);
          end else begin
            r_cnt    <= r_cnt + AW'(1);
            r_we     <= 1'b1;
            r_addr   <= w_wr_addr;
            r_wrdata <= w_wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.addr   = r_addr;
  assign bus.wrdata = r_wrdata;
  assign bus.we     = r_we;
  assign bus.busy   = (r_state == ST_LOAD) || (r_state == ST_CALC) || (r_state == ST_STORE);
  assign bus.done   = (r_state == ST_DONE);
endmodule

// File: tb/tb_qmm_multiplier.sv
// Scoreboard bench for qmm_multiplier: a behavioural model queues expected BRAM writes and done cycles,
// and a negedge monitor compares them against what the DUT actually does.
module tb_qmm_multiplier;
  import qmm_pkg::*;

  localparam int AW  = 2 * $clog2(N) + 1;
  localparam int WPR = N / LANES;

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  qmm_if #(.AW(AW), .WW(32)) bus();
  qmm_multiplier dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  logic [31:0]   mem [1 << AW];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  int            cyc = 0;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (ld_en)       mem[ld_addr] <= ld_data;
    else if (bus.we) mem[bus.addr] <= bus.wrdata;
    bus.rddata <= mem[bus.addr];
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t exp_q[$];
  int  exp_done_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  ma [N][N];
  int  mb [N][N];

  task automatic check(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge aclk) begin
    wr_t e;
    if (aresetn) begin
      if (bus.we) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", bus.addr, bus.wrdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.addr, e.a);
          check("wr_data", bus.wrdata, e.d);
        end
      end
      if (bus.done) begin
        if (exp_done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: at cycle %0d, expected none", cyc);
        end else begin
          check("done_cycle", cyc, exp_done_q.pop_front());
        end
        check("writes_left_at_done", exp_q.size(), 0);
      end
    end
  end

  function automatic int rnd8();
    return int'($signed(8'($urandom)));
  endfunction

  function automatic longint dotp(int i, int j);
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
    return s;
  endfunction

  function automatic int rq(longint acc, int sh);
    longint r = acc;
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
    r = r >>> sh;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  task automatic push_expect(bit md, int sh);
    wr_t e;
    for (int i = 0; i < N; i++) begin
      if (!md) begin
        for (int j = 0; j < N; j++) begin
          e.a = AW'(2 * W + i * N + j);
          e.d = 32'(dotp(i, j));
          exp_q.push_back(e);
        end
      end else begin
        for (int w = 0; w < WPR; w++) begin
          e.a = AW'(2 * W + i * WPR + w);
          e.d = '0;
          for (int l = 0; l < LANES; l++) e.d[l*8 +: 8] = 8'(rq(dotp(i, w * LANES + l), sh));
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic load_mem();
    logic [31:0] wd;
    for (int m = 0; m < 2 * W; m++) begin
      for (int l = 0; l < LANES; l++) begin
        int idx = (m % W) * LANES + l;
        int v   = (m < W) ? ma[idx / N][idx % N] : mb[idx / N][idx % N];
        wd[l*8 +: 8] = 8'(v);
      end
      @(negedge aclk);
      ld_en   = 1'b1;
      ld_addr = AW'(m);
      ld_data = wd;
    end
    @(negedge aclk);
    ld_en = 1'b0;
  endtask

  task automatic fill(int av, int bv);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = av;
        mb[i][j] = bv;
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = rnd8();
        mb[i][j] = rnd8();
      end
  endtask

  task automatic wait_done();
    int b = 0;
    while (!bus.done && b < 2000) begin
      @(negedge aclk);
      b++;
    end
    if (!bus.done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", b);
      exp_q.delete();
      exp_done_q.delete();
    end
    @(negedge aclk);
  endtask

  task automatic start_job(bit md, int sh);
    int b = 0;
    @(negedge aclk);
    while ((bus.busy || bus.done) && b < 1000) begin
      @(negedge aclk);
      b++;
    end
    bus.start = 1'b1;
    bus.mode  = md;
    bus.shift = 5'(sh);
    exp_done_q.push_back(cyc + 2 * W + 2 + N * (N + (md ? WPR : N)));
    @(negedge aclk);
    bus.start = 1'b0;
    bus.mode  = ~md;
    bus.shift = 5'($urandom);
  endtask

  task automatic run_job(bit md, int sh, bit glitch);
    push_expect(md, sh);
    start_job(md, sh);
    if (glitch) begin
      repeat (39) @(negedge aclk);
      bus.start = 1'b1;
      @(negedge aclk);
      bus.start = 1'b0;
    end
    wait_done();
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_wrdata"}, bus.wrdata, 0);
    check({tag, "_we"}, bus.we, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    bit md;
    int sh, b, stray;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.shift = '0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    #1 aresetn = 1'b0;
    #12;
    check_outputs_zero("reset");
    @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = rnd8();
      end
    load_mem();
    run_job(MODE_RAW, 0, 1'b0);

    fill(127, 127);
    load_mem();
    run_job(MODE_RAW, 0, 1'b0);
    check("raw_127x127_word", mem[2 * W], 32'h0001F808);
    run_job(MODE_QUANT, 10, 1'b0);
    check("quant_sh10_word", mem[2 * W], 32'h7E7E7E7E);
    run_job(MODE_QUANT, 0, 1'b0);
    check("quant_sat_pos_word", mem[2 * W], 32'h7F7F7F7F);

    fill(-128, 127);
    load_mem();
    run_job(MODE_QUANT, 0, 1'b0);
    check("quant_sat_neg_word", mem[2 * W], 32'h80808080);

    fill(0, 0);
    ma[0][0] = 2;
    mb[0][0] = 3;
    load_mem();
    run_job(MODE_QUANT, 2, 1'b0);
    check("round_pos6_word", mem[2 * W], 32'h00000002);
    ma[0][0] = -2;
    load_mem();
    run_job(MODE_QUANT, 2, 1'b0);
    check("round_neg6_word", mem[2 * W], 32'h000000FF);

    for (int t = 0; t < 6; t++) begin
      fill_random();
      md = 1'($urandom);
      sh = $urandom_range(0, 15);
      load_mem();
      run_job(md, sh, 1'b0);
    end

    fill_random();
    load_mem();
    run_job(MODE_QUANT, $urandom_range(0, 12), 1'b1);

    fill_random();
    load_mem();
    push_expect(MODE_RAW, 0);
    start_job(MODE_RAW, 0);
    b = 0;
    while (!bus.we && b < 500) begin
      @(negedge aclk);
      b++;
    end
    check("store_reached", bus.we, 1);
    repeat (3) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check_outputs_zero("midstore_reset");
    exp_q.delete();
    exp_done_q.delete();
    stray = 0;
    repeat (4) begin
      @(negedge aclk);
      if (bus.we || bus.busy) stray++;
    end
    check("activity_during_reset", stray, 0);
    aresetn = 1'b1;

    fill_random();
    load_mem();
    run_job(MODE_QUANT, $urandom_range(0, 12), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/qmm_multiplier.md
# qmm_multiplier

Quantized N×N matrix multiplier computing C = A·B on signed DATA_WIDTH operands packed LANES per RAM word, accumulating at ACC_WIDTH. It reads A and B from one shared single-port BRAM, computes one output row at a time on N parallel MAC lanes, and writes C back to the same BRAM. C is written either as raw accumulators or as requantized, saturated DATA_WIDTH values. It is the next-generation replacement for the floating-point N²-PE matrix multiplier in the accelerator IP.

## Interface
- L_RAM_SIZE, 3: log2 of N; N = 2^L_RAM_SIZE.
- DATA_WIDTH, 8: signed operand and quantized-result width.
- WORD_WIDTH, 32: BRAM word width; LANES = WORD_WIDTH/DATA_WIDTH must be ≥ 2 and must divide N.
- ACC_WIDTH, 32: signed accumulator width; must be ≥ 2·DATA_WIDTH + L_RAM_SIZE.
- aclk  in  1  single clock, rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- start  in  1  begin job; sampled only in IDLE.
- mode  in  1  0 = raw (ACC_WIDTH per word, sign-extended to WORD_WIDTH), 1 = quantized (packed DATA_WIDTH); sampled with start.
- shift  in  5  requant right-shift amount; sampled with start.
- rddata  in  WORD_WIDTH  BRAM read data, 1-cycle latency after addr.
- addr  out  2·L_RAM_SIZE+1  BRAM word address.
- wrdata  out  WORD_WIDTH  BRAM write data.
- we  out  1  BRAM write enable.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.

## Operation
- W = N²/LANES. A occupies words 0..W−1 and B occupies W..2W−1, both row-major. Lane k holds bits [k·DATA_WIDTH +: DATA_WIDTH] and the lowest column index. C starts at word 2W.
- States and transitions:
  - IDLE → LOAD when start=1.
  - LOAD → CALC after 2W addresses have been issued and the last word captured.
  - CALC → STORE after N MAC cycles.
  - STORE → CALC when row < N−1.
  - STORE → DONE after row N−1.
  - DONE → IDLE unconditionally.
- LOAD: addr = 0..2W−1 on consecutive cycles. Each word is unpacked into the internal A and B buffers one cycle after its address.
- CALC row i, cycle k = 0..N−1: acc[j] += A[i][k]·B[k][j] for all j in parallel. acc is cleared when row i is entered.
- STORE:
  - Raw mode: N writes, address 2W + i·N + j, wrdata = sign-extended acc[j].
  - Quantized mode: N/LANES writes, address 2W + i·N/LANES + w, each packing acc[w·LANES .. w·LANES+LANES−1] after requantization.
- Requant: r = (acc + (shift>0 ? 2^(shift−1) : 0)) >>> shift, computed at ACC_WIDTH+1 bits so there is no overflow. Saturate r to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- start while busy is ignored. mode and shift changes mid-job have no effect.
- The accumulator cannot overflow under the ACC_WIDTH constraint.

## Timing
- Reset values: addr=0, wrdata=0, we=0, busy=0, done=0, state IDLE, buffers and accumulators cleared. Reset is asynchronous and takes effect mid-operation in any state; no BRAM write occurs after aresetn falls.
- addr, wrdata and we are registered. A write happens on the cycle we=1. we=0 outside STORE.
- With start accepted at cycle 0:
  - LOAD spans cycles 1..2W+1.
  - Each row takes N CALC cycles plus S STORE cycles, where S = N (raw) or N/LANES (quantized).
  - done is high at cycle 2W+2 + N·(N+S).
  - Defaults: quantized done at cycle 114, raw done at cycle 162.
- busy falls on the same cycle done rises. start held high through done begins a new job on the cycle after DONE (first IDLE cycle).

## Structure
- Package qmm_pkg holds:
  - state enum: IDLE, LOAD, CALC, STORE, DONE;
  - derived constants: N, LANES, W;
  - mode encodings.
- Sub-module qmm_requant: combinational rounding shift plus saturation, one instance per lane, parametrised by ACC_WIDTH and DATA_WIDTH.
- The top level holds the FSM, counters, A/B register buffers, N MAC lanes and the pack/unpack logic.

## Test plan
- A = identity, B = random int8, mode=0 → C[i][j] = sign-extended B[i][j] at words 32..95; done at cycle 162.
- All A = 127 and all B = 127, mode=0 → every C word = 129032 (0x0001F808).
- Same operands, mode=1, shift=10 → every byte = 126 (0x7E7E7E7E); shift=0 → saturates to 127 (0x7F7F7F7F).
- All A = −128 and all B = 127, mode=1, shift=0 → every byte = −128 (0x80808080).
- Rounding: a single nonzero product of 6, shift=2 → 2; product −6, shift=2 → −1 (round half up); done at cycle 114.
- start pulsed during CALC → ignored, result unchanged. aresetn low mid-STORE → all outputs 0 immediately, no further we. A following start completes correctly.
